// File: rtl/board_reader.sv
// ============================================================================
//  Module   : board_reader
//  Purpose  : Row-major scan of the 16x16 board store, streaming coloured
//             pixel beats over valid/ready; optional territory scoring
//             (BOARD_READER_SCORE_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module board_reader #(
    parameter int WIDTH  = 16,
    parameter int HEIGHT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [2:0] rd_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_x,
    output logic [3:0] out_y,
    output logic [2:0] out_color,
    output logic       out_last,
    output logic [8:0] red_score,
    output logic [8:0] blue_score
);

    localparam int         c_CELLS      = WIDTH * HEIGHT;
    localparam logic [7:0] c_LAST_INDEX = 8'(c_CELLS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_EMIT    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t     r_state;
    logic [7:0] r_index;
    logic [2:0] w_color;

    function automatic logic [2:0] cell_color(input logic [2:0] code);
        case (code)
            3'd2:    return 3'b100;
            3'd3:    return 3'b001;
            3'd4:    return 3'b110;
            3'd5:    return 3'b011;
            3'd6:    return 3'b101;
            3'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign w_color = cell_color(rd_data);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_index   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_addr   <= '0;
            out_valid <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            out_color <= '0;
            out_last  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ISSUE;
                        r_index <= '0;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= '0;
                    end
                end
                S_ISSUE: begin
                    rd_en   <= 1'b0;
                    r_state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_color <= w_color;
                    out_x     <= r_index[3:0];
                    out_y     <= r_index[7:4];
                    out_last  <= (r_index == c_LAST_INDEX);
                    out_valid <= 1'b1;
                    r_state   <= S_EMIT;
                end
                S_EMIT: begin
                    // The next read is launched on the transfer edge so rd_en trails it by one cycle.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (r_index == c_LAST_INDEX) begin
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 8'd1;
                            rd_addr <= r_index + 8'd1;
                            rd_en   <= 1'b1;
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef BOARD_READER_SCORE_EN
    logic [8:0] r_red_shadow;
    logic [8:0] r_blue_shadow;
    logic       w_red_cell;
    logic       w_blue_cell;

    // Codes 2/4/6 belong to red, 3/5/7 to blue; 0/1 are unowned.
    assign w_red_cell  = (rd_data >= 3'd2) && !rd_data[0];
    assign w_blue_cell = (rd_data >= 3'd3) &&  rd_data[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_red_shadow  <= '0;
            r_blue_shadow <= '0;
            red_score     <= '0;
            blue_score    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_red_shadow  <= '0;
                        r_blue_shadow <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (w_red_cell)  r_red_shadow  <= r_red_shadow + 9'd1;
                    if (w_blue_cell) r_blue_shadow <= r_blue_shadow + 9'd1;
                end
                S_DONE: begin
                    red_score  <= r_red_shadow;
                    blue_score <= r_blue_shadow;
                end
                default: ;
            endcase
        end
    end
`else
    assign red_score  = '0;
    assign blue_score = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_board_reader.sv
// ============================================================================
//  Module   : tb_board_reader
//  Purpose  : Scoreboard bench for board_reader: pixel stream, timing,
//             backpressure, start-while-busy, mid-scan reset and scores.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_board_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       rd_en;
    logic [7:0] rd_addr;
    logic [2:0] rd_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_x;
    logic [3:0] out_y;
    logic [2:0] out_color;
    logic       out_last;
    logic [8:0] red_score;
    logic [8:0] blue_score;

    always #5 clk = ~clk;

    board_reader #(.WIDTH(16), .HEIGHT(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_color  (out_color),
        .out_last   (out_last),
        .red_score  (red_score),
        .blue_score (blue_score)
    );

    logic [2:0] board [256];
    always @(posedge clk) if (rd_en) rd_data <= board[rd_addr];

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [2:0] color;
        logic       last;
    } beat_t;

    beat_t exp_q[$];

    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   s_cyc;
    int   beats;
    int   done_cnt;
    int   done_cyc;
    int   first_cyc;
    int   exp_red;
    int   exp_blue;
    int   t;
    logic prev_rd_en = 1'b0;
    logic done_prev  = 1'b0;
    logic [3:0] hx, hy;
    logic [2:0] hc;
    logic       hl;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] model_color(input logic [2:0] c);
        case (c)
            3'd2:    return 3'b100;
            3'd3:    return 3'b001;
            3'd4:    return 3'b110;
            3'd5:    return 3'b011;
            3'd6:    return 3'b101;
            3'd7:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    function automatic int sc(input int v);
`ifdef BOARD_READER_SCORE_EN
        return v;
`else
        return 0;
`endif
    endfunction

    // Expected beats for the current board are queued as the scan is requested.
    task automatic start_scan();
        beat_t e;
        exp_red  = 0;
        exp_blue = 0;
        for (int i = 0; i < 256; i++) begin
            e.x     = i[3:0];
            e.y     = i[7:4];
            e.color = model_color(board[i]);
            e.last  = (i == 255);
            exp_q.push_back(e);
            case (board[i])
                3'd2, 3'd4, 3'd6: exp_red++;
                3'd3, 3'd5, 3'd7: exp_blue++;
                default: ;
            endcase
        end
        beats     = 0;
        done_cnt  = 0;
        first_cyc = -1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_cyc = cyc;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (done_cnt == 0 && k < 4000) begin
            @(posedge clk); #1;
            k++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_beats(input int n);
        int k;
        k = 0;
        while (beats < n && k < 2000) begin
            @(posedge clk); #1;
            k++;
        end
        if (beats < n) check("beat_timeout", beats, n);
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_en) check("rd_en_pair", prev_rd_en, 0);
            if (done_prev) check("busy_after_done", busy, 0);
            if (out_valid && out_ready) begin
                if (beats == 0) first_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("beat_extra", 1, 0);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    check("beat_xy", {out_y, out_x}, {e.y, e.x});
                    check("beat_color", out_color, e.color);
                    check("beat_last", out_last, e.last);
                end
                beats++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", busy, 1);
            end
        end
        prev_rd_en = rd_en;
        done_prev  = done && !reset;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        out_ready = 1'b0;
        rd_data   = '0;
        for (int i = 0; i < 256; i++) board[i] = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctrl", {busy, done, rd_en, out_valid, out_last}, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_pix", {out_x, out_y, out_color}, 0);
        check("rst_score", {red_score, blue_score}, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // All-zero board, ready held high
        out_ready = 1'b1;
        start_scan();
        check("zero_first_rd", {busy, rd_en, rd_addr}, {1'b1, 1'b1, 8'd0});
        wait_done();
        check("zero_beats", beats, 256);
        check("zero_first_cyc", first_cyc, s_cyc + 2);
        check("zero_done_cyc", done_cyc, s_cyc + 768);
        check("zero_done_cnt", done_cnt, 1);
        check("zero_red", red_score, 0);
        check("zero_blue", blue_score, 0);

        // Mixed board
        for (int i = 0; i < 256; i++) board[i] = 3'd1;
        board[0]        = 3'd2;
        board[3*16 + 4] = 3'd5;
        board[255]      = 3'd7;
        board[7*16 + 7] = 3'd6;
        start_scan();
        wait_done();
        check("mix_beats", beats, 256);
        check("mix_done_cyc", done_cyc, s_cyc + 768);
        check("mix_red", red_score, sc(exp_red));
        check("mix_blue", blue_score, sc(exp_blue));
        check("mix_red_abs", red_score, sc(2));

        // Backpressure: beat 3 stalled for 5 cycles
        out_ready = 1'b0;
        start_scan();
        for (int b = 0; b < 256; b++) begin
            t = 0;
            while (!out_valid && t < 20) begin
                @(posedge clk); #1;
                t++;
            end
            if (!out_valid) check("bp_valid_timeout", 0, 1);
            if (b == 2) begin
                hx = out_x; hy = out_y; hc = out_color; hl = out_last;
                repeat (5) begin
                    @(negedge clk);
                    check("bp_hold", {out_valid, out_x, out_y, out_color, out_last},
                          {1'b1, hx, hy, hc, hl});
                    check("bp_no_rd", rd_en, 0);
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
            if (b == 2) check("bp_rd_after", {rd_en, rd_addr}, {1'b1, 8'd3});
        end
        wait_done();
        check("bp_beats", beats, 256);
        check("bp_red", red_score, sc(2));

        // Start while busy is ignored
        out_ready = 1'b1;
        start_scan();
        wait_beats(50);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        repeat (20) @(posedge clk);
        #1;
        check("sb_beats", beats, 256);
        check("sb_done_cnt", done_cnt, 1);
        check("sb_idle", busy, 0);

        // Prior complete scan scoring 10/20, then reset mid-scan
        for (int i = 0; i < 256; i++) board[i] = 3'd0;
        for (int i = 0; i < 10; i++)  board[i] = (i % 2 == 0) ? 3'd2 : 3'd4;
        for (int i = 10; i < 30; i++) board[i] = (i % 2 == 0) ? 3'd7 : 3'd3;
        start_scan();
        wait_done();
        check("pre_red", red_score, sc(10));
        check("pre_blue", blue_score, sc(20));
        start_scan();
        wait_beats(100);
        check("hold_scores", {red_score, blue_score}, {9'(sc(10)), 9'(sc(20))});
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ctrl", {out_valid, busy, rd_en, done}, 0);
        check("rst_mid_score", {red_score, blue_score}, 0);
        reset = 1'b0;
        exp_q.delete();
        done_cnt = 0;
        repeat (800) @(posedge clk);
        #1;
        check("rst_mid_no_done", done_cnt, 0);
        check("rst_mid_idle", {busy, out_valid}, 0);
        start_scan();
        wait_done();
        check("restart_beats", beats, 256);
        check("restart_first_cyc", first_cyc, s_cyc + 2);
        check("restart_red", red_score, sc(10));
        check("restart_blue", blue_score, sc(20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/board_reader.md
# board_reader

Scans the 16x16 game-board cell store in row-major order and streams each cell out as a coloured pixel beat to the display path, using a valid/ready handshake. It is the read side of the board store: game logic writes cell codes, this block reads them back through a one-cycle-latency read port. It optionally tallies per-player territory while scanning and publishes the scores when a full scan completes.

## Interface

Parameters:
- `WIDTH`, default 16: columns. Fixed at 16; the address and `out_x` widths assume it.
- `HEIGHT`, default 16: rows. Fixed at 16.

Ports:
- `clk`, input, 1: sole clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `start`, input, 1: single-cycle request to begin a full scan.
- `busy`, output, 1: high from the cycle after `start` is accepted until `done`.
- `done`, output, 1: one-cycle pulse after the final beat transfers.
- `rd_en`, output, 1: read strobe to the board store.
- `rd_addr`, output, 8: cell address, `{y[3:0], x[3:0]}`.
- `rd_data`, input, 3: cell code, valid exactly one cycle after `rd_en`.
- `out_valid`, output, 1: pixel beat valid.
- `out_ready`, input, 1: downstream accepts the beat.
- `out_x`, output, 4: column of the beat.
- `out_y`, output, 4: row of the beat.
- `out_color`, output, 3: RGB colour of the beat.
- `out_last`, output, 1: high on the beat for cell (15,15).
- `red_score`, output, 9: red-owned cells in the last completed scan.
- `blue_score`, output, 9: blue-owned cells in the last completed scan.

## Operation

- **Reset:** all outputs are 0, the FSM is in IDLE, the index is 0, and the shadow and published scores are 0.
- **FSM states:**
  - IDLE: on `start` go to ISSUE; clear the shadow counters and index.
  - ISSUE: drive `rd_en=1` and `rd_addr=index`; go to CAPTURE.
  - CAPTURE: register `rd_data` into the colour, x and y output registers; update the shadow counters; go to EMIT.
  - EMIT: `out_valid=1`. On `out_ready`, the beat transfers. If index is 255, go to DONE; otherwise increment the index and go to ISSUE.
  - DONE: pulse `done`, copy the shadow counters to `red_score`/`blue_score`, and go to IDLE.
- **Cell codes to colour, ownership:**
  - 0 or 1 (empty): `000`, no owner.
  - 2 (red territory): `100`, red.
  - 3 (blue territory): `001`, blue.
  - 4 (red player): `110`, red.
  - 5 (blue player): `011`, blue.
  - 6 (red bomb): `101`, red.
  - 7 (blue bomb): `111`, blue.
- **Scan order:** y outer, x inner. The index is an 8-bit counter with `x = index[3:0]` and `y = index[7:4]`; it does not wrap past 255.
- **Scores:** 9-bit counters, maximum 256. Published scores change only in DONE. An aborted scan never updates them.

## Timing

- `start` sampled high in IDLE at edge N:
  - ISSUE, `busy=1`, `rd_en=1`, `rd_addr=0` in cycle N+1.
  - CAPTURE in cycle N+2.
  - `out_valid=1` in cycle N+3.
- Minimum throughput is 3 cycles per cell. With `out_ready` held high:
  - Last beat is in cycle N+768.
  - `done=1` and `busy=1` in cycle N+769.
  - `busy=0` in cycle N+770.
- **Backpressure:** while `out_valid=1` and `out_ready=0`, `out_x`, `out_y`, `out_color` and `out_last` hold stable. No `rd_en` is issued.
- `rd_en` is never high in two consecutive cycles.
- `start` while busy, or in the DONE cycle, is ignored.
- **`reset` mid-scan:**
  - Next cycle: IDLE, `out_valid=0`, `busy=0`, `rd_en=0`.
  - Published scores are cleared to 0.
  - No `done` pulse.
- `start` and `reset` in the same cycle: reset wins.

## Configuration

- `BOARD_READER_SCORE_EN` defined: the shadow and published score counters are built and behave as above.
- Not defined:
  - No counters are built.
  - `red_score` and `blue_score` are tied to 0.
  - Pixel stream, FSM and timing are unchanged.

## Test plan

- **All-zero board:** `start` with `out_ready=1` -> 256 beats, all `out_color=000`, x/y in row-major order, `out_last` only on beat 256 at (15,15), `done` at N+769, scores 0/0.
- **Mixed board:** (0,0)=2, (4,3)=5, (15,15)=7, (7,7)=6, rest 1 -> colours `100`, `011`, `111`, `101` at those beats, `red_score=2`, `blue_score=2` after `done`.
- **Backpressure:** `out_ready` low for 5 cycles on beat 3 -> beat fields stable, no `rd_en` during the stall, beat 4 `rd_en` one cycle after the transfer.
- **Start while busy:** `start` pulsed at beat 50 -> ignored, exactly 256 beats and one `done`.
- **Reset mid-scan:** `reset` at beat 100 after a prior complete scan scored 10/20 -> `out_valid=0` next cycle, scores 0/0, no `done`. A new `start` restarts at (0,0).
- **Macro undefined:** mixed-board scan -> identical beats and timing, scores stay 0/0.
